// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, port ids, FSM states
// and the alignment check applied to latched requests.
package dmem_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic P_CORE = 1'b0;
  localparam logic P_DBG  = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StMerge  = 2'd2
  } state_e;

  // Reserved size is folded in here so the top has a single error term for size/offset.
  function automatic logic size_misaligned(logic [1:0] size, logic [1:0] offset);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the shared response bus and the data-memory port.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32
);

  logic          p0_req_valid;
  logic          p0_req_ready;
  logic          p0_req_we;
  logic [1:0]    p0_req_size;
  logic          p0_req_unsigned;
  logic [AW-1:0] p0_req_addr;
  logic [31:0]   p0_req_wdata;

  logic          p1_req_valid;
  logic          p1_req_ready;
  logic          p1_req_we;
  logic [1:0]    p1_req_size;
  logic          p1_req_unsigned;
  logic [AW-1:0] p1_req_addr;
  logic [31:0]   p1_req_wdata;

  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_size, p0_req_unsigned, p0_req_addr, p0_req_wdata,
    input  p1_req_valid, p1_req_we, p1_req_size, p1_req_unsigned, p1_req_addr, p1_req_wdata,
    input  mem_rd,
    output p0_req_ready, p1_req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wd
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_size, p0_req_unsigned, p0_req_addr, p0_req_wdata,
    output p1_req_valid, p1_req_we, p1_req_size, p1_req_unsigned, p1_req_addr, p1_req_wdata,
    output mem_rd,
    input  p0_req_ready, p1_req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling for a 32-bit word: extracts and extends load data, and
// builds the merged word for byte/half stores.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{offset[1], 4'b0000} +: 16];

    load_data  = word;
    store_word = word;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters access to a single-port word memory, with
// registered responses and read-modify-write for sub-word stores.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned AW    = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          last_grant_q;
  logic          port_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merge_q, merge_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          any_valid;
  logic          grant;
  logic          handshake;
  logic [AW-1:0] word_idx;
  logic          req_err;
  logic [31:0]   align_word;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  // Arbitration: a lone requester always wins; on contention the port not served last wins.
  always_comb begin
    any_valid = bus.p0_req_valid | bus.p1_req_valid;
    if (bus.p0_req_valid && bus.p1_req_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.p1_req_valid ? P_DBG : P_CORE;
    end
    handshake        = (state_q == StIdle) && any_valid;
    bus.p0_req_ready = handshake && (grant == P_CORE);
    bus.p1_req_ready = handshake && (grant == P_DBG);
  end

  assign word_idx = addr_q >> 2;
  assign req_err  = size_misaligned(size_q, addr_q[1:0]) || (word_idx >= AW'(DEPTH));

  // MERGE works on the captured word; ACCESS works on the live memory read.
  assign align_word = (state_q == StMerge) ? merge_q : bus.mem_rd;

  dmem_lane_align u_lane_align (
    .word        (align_word),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus.mem_we  = 1'b0;
    bus.mem_wd  = 32'h0;

    case (state_q)
      StIdle: begin
        if (any_valid) state_d = StAccess;
      end
      StAccess: begin
        if (req_err) begin
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end else if (!we_q) begin
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end else if (size_q == SZ_W) begin
          bus.mem_we  = 1'b1;
          bus.mem_wd  = wdata_q;
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end else begin
          merge_d = bus.mem_rd;
          state_d = StMerge;
        end
      end
      StMerge: begin
        bus.mem_we  = 1'b1;
        bus.mem_wd  = store_word;
        rsp_valid_d = port_q ? 2'b10 : 2'b01;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_addr  = word_idx;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= P_DBG;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (handshake) begin
        port_q       <= grant;
        last_grant_q <= grant;
        we_q         <= grant ? bus.p1_req_we       : bus.p0_req_we;
        size_q       <= grant ? bus.p1_req_size     : bus.p0_req_size;
        uns_q        <= grant ? bus.p1_req_unsigned : bus.p0_req_unsigned;
        addr_q       <= grant ? bus.p1_req_addr     : bus.p0_req_addr;
        wdata_q      <= grant ? bus.p1_req_wdata    : bus.p0_req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver queues expected responses and memory
// writes at each handshake; a negedge monitor pops and checks them as the DUT emits them.
module tb_dmem_arbiter;

  localparam int DEPTH = 100;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    logic        wr;
    logic [31:0] wr_data;
  } req_t;

  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk;
  logic        rst;
  int          cyc;
  int          n_chk;
  int          n_bad;
  logic [31:0] mem [DEPTH];
  logic [6:0]  mem_idx;

  req_t pend [2];
  logic pend_valid [2];
  req_t stim0 [$];
  req_t stim1 [$];
  rsp_t rsp_q [$];
  wr_t  wr_q [$];
  int   exp_grant [$];

  dmem_arbiter_if #(.AW(32)) bus ();

  dmem_arbiter #(
    .DEPTH (DEPTH),
    .AW    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.p0_req_valid    = pend_valid[0];
  assign bus.p0_req_we       = pend[0].we;
  assign bus.p0_req_size     = pend[0].size;
  assign bus.p0_req_unsigned = pend[0].uns;
  assign bus.p0_req_addr     = pend[0].addr;
  assign bus.p0_req_wdata    = pend[0].wdata;
  assign bus.p1_req_valid    = pend_valid[1];
  assign bus.p1_req_we       = pend[1].we;
  assign bus.p1_req_size     = pend[1].size;
  assign bus.p1_req_unsigned = pend[1].uns;
  assign bus.p1_req_addr     = pend[1].addr;
  assign bus.p1_req_wdata    = pend[1].wdata;

  assign mem_idx    = bus.mem_addr[6:0];
  assign bus.mem_rd = (bus.mem_addr < 32'(DEPTH)) ? mem[mem_idx] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.mem_we && bus.mem_addr < 32'(DEPTH)) mem[mem_idx] <= bus.mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t want finish", $time);
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err,
                              int lat, logic wr, logic [31:0] wr_data);
    req_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.exp_rdata = exp_rdata; r.exp_err = exp_err; r.lat = lat; r.wr = wr; r.wr_data = wr_data;
    return r;
  endfunction

  task automatic load_heads();
    if (!pend_valid[0] && stim0.size() > 0) begin pend[0] = stim0.pop_front(); pend_valid[0] = 1; end
    if (!pend_valid[1] && stim1.size() > 0) begin pend[1] = stim1.pop_front(); pend_valid[1] = 1; end
  endtask

  task automatic on_accept(input int p);
    req_t r;
    rsp_t e;
    wr_t  w;
    r = pend[p];
    if (exp_grant.size() > 0) chk("grant_order", 32'(p), 32'(exp_grant.pop_front()));
    e.onehot = (p == 1) ? 2'b10 : 2'b01;
    e.rdata  = r.exp_rdata;
    e.err    = r.exp_err;
    e.cyc    = cyc + r.lat;
    rsp_q.push_back(e);
    if (r.wr) begin
      w.addr = r.addr >> 2;
      w.data = r.wr_data;
      w.cyc  = cyc + r.lat - 1;
      wr_q.push_back(w);
    end
  endtask

  // Drive queued requests, holding valid until accepted, until everything has drained.
  task automatic run();
    int  budget;
    logic acc0, acc1;
    budget = 300;
    load_heads();
    while ((pend_valid[0] || pend_valid[1] || stim0.size() > 0 || stim1.size() > 0 ||
            rsp_q.size() > 0 || wr_q.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      acc0 = pend_valid[0] && bus.p0_req_ready;
      acc1 = pend_valid[1] && bus.p1_req_ready;
      if (acc0) on_accept(0);
      if (acc1) on_accept(1);
      @(posedge clk);
      #1;
      if (acc0) pend_valid[0] = 0;
      if (acc1) pend_valid[1] = 0;
      load_heads();
    end
    if (budget == 0) chk("run_timeout", 32'(rsp_q.size() + wr_q.size()) | 32'h8000_0000, 32'h0);
    chk("grant_left", 32'(exp_grant.size()), 32'h0);
  endtask

  // Monitor: every response and every memory write must match the head of its queue.
  initial begin
    logic prev0, prev1;
    rsp_t e;
    wr_t  w;
    prev0 = 0;
    prev1 = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", {30'h0, bus.rsp_valid}, 32'h0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_port", {30'h0, bus.rsp_valid}, {30'h0, e.onehot});
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {31'h0, bus.mem_we}, 32'h0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", bus.mem_addr, w.addr);
          chk("wr_data", bus.mem_wd, w.data);
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if (bus.p0_req_ready && bus.p1_req_ready) chk("ready_both", 32'h1, 32'h0);
      if (rst && bus.p0_req_ready && prev0) chk("ready0_pulse", 32'h1, 32'h0);
      if (rst && bus.p1_req_ready && prev1) chk("ready1_pulse", 32'h1, 32'h0);
      prev0 = rst && bus.p0_req_ready;
      prev1 = rst && bus.p1_req_ready;
    end
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 0;
    pend_valid[0] = 0;
    pend_valid[1] = 0;
    pend[0] = mk(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 2, 0, 32'h0);
    pend[1] = pend[0];
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("reset_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_mem_wd", bus.mem_wd, 32'h0);
    chk("reset_ready", {30'h0, bus.p1_req_ready, bus.p0_req_ready}, 32'h0);
    rst = 1;

    // Word store then word load on port 0.
    stim0.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF));
    stim0.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0));
    run();

    // Byte read-modify-write and signed/unsigned byte loads on port 1.
    stim1.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 1, 32'h11223344));
    stim1.push_back(mk(1, 2'b00, 0, 32'h12, 32'h000000AA, 32'h0, 0, 3, 1, 32'h11AA3344));
    stim1.push_back(mk(0, 2'b00, 0, 32'h12, 32'h0, 32'hFFFFFFAA, 0, 2, 0, 32'h0));
    stim1.push_back(mk(0, 2'b00, 1, 32'h12, 32'h0, 32'h000000AA, 0, 2, 0, 32'h0));
    run();
    chk("mem_word4", mem[4], 32'h11AA3344);

    // Upper-half store into a zero word, then half and word loads.
    stim0.push_back(mk(1, 2'b01, 0, 32'h16, 32'h0000BEEF, 32'h0, 0, 3, 1, 32'hBEEF0000));
    stim0.push_back(mk(0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFFBEEF, 0, 2, 0, 32'h0));
    stim0.push_back(mk(0, 2'b01, 1, 32'h14, 32'h0, 32'h00000000, 0, 2, 0, 32'h0));
    stim0.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0, 32'hBEEF0000, 0, 2, 0, 32'h0));
    run();

    // Rejected accesses: no write, rdata 0, err 1.
    stim0.push_back(mk(0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1, 2, 0, 32'h0));
    stim1.push_back(mk(1, 2'b01, 0, 32'h05, 32'h1234, 32'h0, 1, 2, 0, 32'h0));
    stim0.push_back(mk(0, 2'b10, 0, 32'd400, 32'h0, 32'h0, 1, 2, 0, 32'h0));
    stim1.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 2, 0, 32'h0));
    run();
    chk("mem_word1", mem[1], 32'h0);
    chk("mem_word5", mem[5], 32'hBEEF0000);

    // Both ports valid straight out of reset: grants alternate starting with port 0.
    rst = 0;
    @(posedge clk);
    stim0.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 2, 0, 32'h0));
    stim0.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000011, 0, 2, 0, 32'h0));
    stim1.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0, 32'hBEEF0000, 0, 2, 0, 32'h0));
    stim1.push_back(mk(1, 2'b10, 0, 32'h18, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D));
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    load_heads();
    @(posedge clk);
    #1;
    rst = 1;
    run();

    // Reset during MERGE of a byte store: the write and its response are abandoned.
    pend[0] = mk(1, 2'b00, 0, 32'h18, 32'h00000055, 32'h0, 0, 3, 1, 32'hCAFEF055);
    pend_valid[0] = 1;
    @(negedge clk);
    chk("abort_ready", {31'h0, bus.p0_req_ready}, 32'h1);
    @(posedge clk);
    #1;
    pend_valid[0] = 0;
    @(posedge clk);
    #1;
    chk("merge_we", {31'h0, bus.mem_we}, 32'h1);
    chk("merge_wd", bus.mem_wd, 32'hCAFEF055);
    rst = 0;
    #1;
    chk("abort_we", {31'h0, bus.mem_we}, 32'h0);
    repeat (3) @(posedge clk);
    chk("abort_word6", mem[6], 32'hCAFEF00D);
    stim0.push_back(mk(0, 2'b10, 0, 32'h18, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0));
    stim1.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 2, 0, 32'h0));
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    load_heads();
    #1;
    rst = 1;
    run();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
